// File: rtl/arb_mux_nx1.sv
// rtl/arb_mux_nx1.sv - N-to-1 channel mux with ctrl-select or round-robin grant and a one-entry output register
module arb_mux_nx1 #(
  parameter  int W    = 8,
  parameter  int N    = 3,
  parameter  int MODE = 0,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SW-1:0]  ctrl,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready,
  output logic           err
);

  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  logic          can_load;
  logic          grant_valid;
  logic          in_xfer;
  logic          err_next;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [W-1:0]  sel_data;

  assign can_load = !out_valid || out_ready;

  // Round-robin scans from the farthest candidate down so the nearest to ptr+1 wins.
  always_comb begin
    g           = '0;
    grant_valid = 1'b0;
    if (MODE == 0) begin
      g           = ctrl;
      grant_valid = ({1'b0, ctrl} < N_EXT);
    end else begin
      for (int k = N; k >= 1; k--) begin
        int idx;
        idx = (int'(ptr) + k) % N;
        if (in_valid[idx]) begin
          g           = SW'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && can_load && grant_valid && (g == SW'(i));
      if (g == SW'(i)) sel_data = in_data[i*W +: W];
    end
  end

  assign in_xfer  = |(in_ready & in_valid);
  assign err_next = (MODE == 0) ? !grant_valid : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      err       <= 1'b0;
      ptr       <= SW'(N - 1);
    end else begin
      err <= err_next;
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= g;
        if (MODE != 0) ptr <= g;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb/tb_arb_mux_nx1.sv - directed vector bench for arb_mux_nx1 in ctrl-select and round-robin modes
module tb_arb_mux_nx1;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  ctrl0, oc0;
  logic [2:0]  iv0, ir0;
  logic [23:0] id0;
  logic [7:0]  od0;
  logic        ov0, or0, err0;

  logic [1:0]  ctrl1, oc1;
  logic [2:0]  iv1, ir1;
  logic [23:0] id1;
  logic [7:0]  od1;
  logic        ov1, or1, err1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_mux_nx1 #(.W(8), .N(3), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .ctrl(ctrl0), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_chan(oc0),
    .out_ready(or0), .err(err0)
  );

  arb_mux_nx1 #(.W(8), .N(3), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .ctrl(ctrl1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_chan(oc1),
    .out_ready(or1), .err(err1)
  );

  typedef struct packed {
    logic [1:0] ctrl;
    logic [2:0] iv;
    logic       ordy;
    logic [2:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] oc;
    logic       er;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             ctrl   iv      ordy  rdy     ov    od     oc     er
    vecs[0] = {2'd1, 3'b010, 1'b1, 3'b010, 1'b1, 8'hA5, 2'd1, 1'b0};
    vecs[1] = {2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA5, 2'd1, 1'b1};
    vecs[2] = {2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA5, 2'd1, 1'b1};
    vecs[3] = {2'd0, 3'b000, 1'b1, 3'b001, 1'b0, 8'hA5, 2'd1, 1'b0};
    vecs[4] = {2'd2, 3'b100, 1'b0, 3'b100, 1'b1, 8'h7E, 2'd2, 1'b0};
    vecs[5] = {2'd0, 3'b001, 1'b0, 3'b000, 1'b1, 8'h7E, 2'd2, 1'b0};
    vecs[6] = {2'd0, 3'b001, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b0};
    vecs[7] = {2'd1, 3'b000, 1'b1, 3'b010, 1'b0, 8'h11, 2'd0, 1'b0};

    rst = 1'b1;
    ctrl0 = 2'd0; iv0 = '0; id0 = {8'h7E, 8'hA5, 8'h11}; or0 = 1'b0;
    ctrl1 = 2'd0; iv1 = '0; id1 = {8'hC2, 8'hC1, 8'hC0}; or1 = 1'b0;
    #1;
    chk("rst u0 out_valid", 32'(ov0), 32'h0);
    chk("rst u0 out_data", 32'(od0), 32'h0);
    chk("rst u0 out_chan", 32'(oc0), 32'h0);
    chk("rst u0 err", 32'(err0), 32'h0);
    chk("rst u0 in_ready", 32'(ir0), 32'h0);
    chk("rst u1 out_valid", 32'(ov1), 32'h0);
    chk("rst u1 in_ready", 32'(ir1), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ctrl-select mode vector table
    for (int i = 0; i < 8; i++) begin
      ctrl0 = vecs[i].ctrl;
      iv0   = vecs[i].iv;
      or0   = vecs[i].ordy;
      #2;
      chk($sformatf("v%0d in_ready", i), 32'(ir0), 32'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(ov0), 32'(vecs[i].ov));
      chk($sformatf("v%0d out_data", i), 32'(od0), 32'(vecs[i].od));
      chk($sformatf("v%0d out_chan", i), 32'(oc0), 32'(vecs[i].oc));
      chk($sformatf("v%0d err", i), 32'(err0), 32'(vecs[i].er));
    end
    iv0 = '0; or0 = 1'b0;

    // round-robin with all channels requesting
    iv1 = 3'b111; or1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("rr%0d in_ready", k), 32'(ir1), 32'(3'b001 << (k % 3)));
      tick();
      chk($sformatf("rr%0d out_chan", k), 32'(oc1), 32'(k % 3));
      chk($sformatf("rr%0d out_data", k), 32'(od1), 32'(8'hC0 + k % 3));
      chk($sformatf("rr%0d out_valid", k), 32'(ov1), 32'h1);
      chk($sformatf("rr%0d err", k), 32'(err1), 32'h0);
    end
    iv1 = '0; or1 = 1'b0;

    // backpressure: hold 3C for 4 cycles with a new word pending
    ctrl0 = 2'd0; iv0 = 3'b001; or0 = 1'b0; id0 = {8'h7E, 8'hA5, 8'h3C};
    #2 chk("bp load in_ready", 32'(ir0), 32'h1);
    tick();
    chk("bp load out_data", 32'(od0), 32'h3C);
    id0 = {8'h7E, 8'hA5, 8'h55};
    for (int k = 0; k < 4; k++) begin
      #2 chk($sformatf("bp%0d in_ready", k), 32'(ir0), 32'h0);
      tick();
      chk($sformatf("bp%0d out_data", k), 32'(od0), 32'h3C);
      chk($sformatf("bp%0d out_valid", k), 32'(ov0), 32'h1);
    end
    or0 = 1'b1;
    #2 chk("drain in_ready", 32'(ir0), 32'h1);
    tick();
    chk("drain out_data", 32'(od0), 32'h55);
    chk("drain out_valid", 32'(ov0), 32'h1);
    id0 = {8'h7E, 8'hA5, 8'h3C};
    tick();
    chk("reload out_data", 32'(od0), 32'h3C);
    iv0 = '0; or0 = 1'b0;
    tick();
    chk("hold out_valid", 32'(ov0), 32'h1);
    chk("u1 hold out_valid", 32'(ov1), 32'h1);

    // asynchronous reset mid-cycle discards held words
    #2 rst = 1'b1;
    #1;
    chk("arst u0 out_valid", 32'(ov0), 32'h0);
    chk("arst u0 out_data", 32'(od0), 32'h0);
    chk("arst u0 out_chan", 32'(oc0), 32'h0);
    chk("arst u0 in_ready", 32'(ir0), 32'h0);
    chk("arst u1 out_valid", 32'(ov1), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // round-robin restarts at channel 0, then wraps 2 -> 0
    iv1 = 3'b111; or1 = 1'b1;
    #2 chk("post-rst rr in_ready", 32'(ir1), 32'h1);
    tick();
    chk("post-rst rr out_chan", 32'(oc1), 32'h0);
    iv1 = 3'b100;
    #2 chk("rr ch2 in_ready", 32'(ir1), 32'h4);
    tick();
    chk("rr ch2 out_chan", 32'(oc1), 32'h2);
    iv1 = 3'b011;
    #2 chk("rr wrap in_ready", 32'(ir1), 32'h1);
    tick();
    chk("rr wrap out_chan", 32'(oc1), 32'h0);
    chk("rr wrap out_data", 32'(od1), 32'hC0);
    chk("rr err", 32'(err1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
